// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster constants, TMDS control codes and sync helpers
// used by the timing generator and the downstream encoders.
package video_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int CW_DEF       = 11;

  // 10-bit TMDS control symbols indexed by CD = {vsync, hsync}
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bus_t;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Enable-gated shift register with a configurable reset value; depth 0
// degenerates to a straight wire.
module sig_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_sr
      logic [WIDTH-1:0] stages [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= RST_VAL;
        end else if (en) begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: x/y counters, registered stage-0 decode, strobes
// and a pipeline-matching delay line for hsync/vsync/de.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = CW_DEF,
  parameter int   PIPE_DLY = 1
) (
  input  logic          pixclk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          fetch,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] x_nxt, y_nxt;
  logic          hs_raw, vs_raw;
  sync_bus_t     stage0, delayed;

  always_comb begin
    x_nxt = x + CW'(1);
    y_nxt = y;
    if (x == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y == V_LAST) ? '0 : y + CW'(1);
    end
  end

  // Decode is taken from the next coordinates so it lands in the same cycle as x/y
  always_ff @(posedge pixclk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      fetch  <= 1'b0;
      hs_raw <= 1'b0;
      vs_raw <= 1'b0;
    end else if (en) begin
      x      <= x_nxt;
      y      <= y_nxt;
      fetch  <= (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
      hs_raw <= (x_nxt >= HS_START) && (x_nxt < HS_END);
      vs_raw <= (y_nxt >= VS_START) && (y_nxt < VS_END);
    end
  end

  assign line_start  = en && !rst && (x == '0);
  assign frame_start = line_start && (y == '0);

  assign stage0.hsync = sync_level(hs_raw, HS_POL);
  assign stage0.vsync = sync_level(vs_raw, VS_POL);
  assign stage0.de    = fetch;

  sig_delay #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({~HS_POL, ~VS_POL, 1'b0})
  ) u_sync_dly (
    .clk  (pixclk),
    .rst  (rst),
    .en   (en),
    .din  (stage0),
    .dout (delayed)
  );

  assign hsync = delayed.hsync;
  assign vsync = delayed.vsync;
  assign de    = delayed.de;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three configurations driven in lockstep against
// a behavioural raster model through an expected-value queue.
module tb_video_timing_gen;

  logic pixclk, rst, en;

  logic [10:0] x_o [3];
  logic [10:0] y_o [3];
  logic fetch_o [3], ls_o [3], fs_o [3], hs_o [3], vs_o [3], de_o [3];
  logic [27:0] obs [3];
  logic [27:0] last_obs [3];

  video_timing_gen #(.PIPE_DLY(0)) u_d0 (
    .pixclk(pixclk), .rst(rst), .en(en), .x(x_o[0]), .y(y_o[0]), .fetch(fetch_o[0]),
    .line_start(ls_o[0]), .frame_start(fs_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]), .de(de_o[0]));

  video_timing_gen #(.PIPE_DLY(2)) u_d2 (
    .pixclk(pixclk), .rst(rst), .en(en), .x(x_o[1]), .y(y_o[1]), .fetch(fetch_o[1]),
    .line_start(ls_o[1]), .frame_start(fs_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]), .de(de_o[1]));

  video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(4), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .PIPE_DLY(1)) u_small (
    .pixclk(pixclk), .rst(rst), .en(en), .x(x_o[2]), .y(y_o[2]), .fetch(fetch_o[2]),
    .line_start(ls_o[2]), .frame_start(fs_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]), .de(de_o[2]));

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {x_o[g], y_o[g], fetch_o[g], ls_o[g], fs_o[g], hs_o[g], vs_o[g], de_o[g]};
  end

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int ha [3], hfp [3], hsw [3], hbp [3], va [3], vfp [3], vsw [3], vbp [3], dl [3];
  logic hp [3], vp [3];

  int mx [3], my [3];
  logic mf [3], mhs [3], mvs [3];
  logic [2:0] mp [3][8];

  logic [27:0] sb [$];

  int n_hs0_low, n_de0, n_ls_s, n_fs_s, n_hs_s_hi, n_vs_s_lo;
  int last_fs, fs_iv;
  int d2_fall_x, d2_de_rise_x, d2_de_rise_y;
  logic d2_hs_prev, d2_de_prev;

  function automatic logic pol(input logic a, input logic p);
    return a ? p : ~p;
  endfunction

  function automatic logic [27:0] model_vec(input int k);
    logic [2:0] sy;
    logic ls;
    sy = (dl[k] == 0) ? {pol(mhs[k], hp[k]), pol(mvs[k], vp[k]), mf[k]} : mp[k][dl[k]-1];
    ls = en && !rst && (mx[k] == 0);
    return {11'(mx[k]), 11'(my[k]), mf[k], ls, ls && (my[k] == 0), sy};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mx[k] = 0; my[k] = 0; mf[k] = 0; mhs[k] = 0; mvs[k] = 0;
      for (int i = 0; i < 8; i++) mp[k][i] = {~hp[k], ~vp[k], 1'b0};
    end
  endtask

  task automatic model_step(input int k);
    int ht, vt, nx, ny;
    if (en) begin
      for (int i = 7; i > 0; i--) mp[k][i] = mp[k][i-1];
      mp[k][0] = {pol(mhs[k], hp[k]), pol(mvs[k], vp[k]), mf[k]};
      ht = ha[k] + hfp[k] + hsw[k] + hbp[k];
      vt = va[k] + vfp[k] + vsw[k] + vbp[k];
      nx = (mx[k] == ht - 1) ? 0 : mx[k] + 1;
      ny = (mx[k] == ht - 1) ? ((my[k] == vt - 1) ? 0 : my[k] + 1) : my[k];
      mf[k]  = (nx < ha[k]) && (ny < va[k]);
      mhs[k] = (nx >= ha[k] + hfp[k]) && (nx < ha[k] + hfp[k] + hsw[k]);
      mvs[k] = (ny >= va[k] + vfp[k]) && (ny < va[k] + vfp[k] + vsw[k]);
      mx[k] = nx;
      my[k] = ny;
    end
  endtask

  task automatic step(input logic en_v);
    logic [27:0] e, o;
    @(negedge pixclk);
    en = en_v;
    for (int k = 0; k < 3; k++) sb.push_back(model_vec(k));
    #1;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      o = obs[k];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_dut%0d cyc=%0d got x=%0d y=%0d flags=%b exp x=%0d y=%0d flags=%b",
                 k, cyc, o[27:17], o[16:6], o[5:0], e[27:17], e[16:6], e[5:0]);
      end
      last_obs[k] = o;
    end
    if (en) begin
      if (!hs_o[0]) n_hs0_low++;
      if (de_o[0]) n_de0++;
      if (ls_o[2]) n_ls_s++;
      if (fs_o[2]) begin n_fs_s++; fs_iv = cyc - last_fs; last_fs = cyc; end
      if (hs_o[2]) n_hs_s_hi++;
      if (!vs_o[2]) n_vs_s_lo++;
    end
    if (d2_hs_prev && !hs_o[1]) d2_fall_x = int'(x_o[1]);
    if (!d2_de_prev && de_o[1]) begin d2_de_rise_x = int'(x_o[1]); d2_de_rise_y = int'(y_o[1]); end
    d2_hs_prev = hs_o[1];
    d2_de_prev = de_o[1];
    @(posedge pixclk);
    for (int k = 0; k < 3; k++) model_step(k);
    cyc++;
  endtask

  task automatic check_reset_vals(input string tag);
    logic [27:0] e;
    for (int k = 0; k < 3; k++) begin
      e = {22'd0, 3'b000, ~hp[k], ~vp[k], 1'b0};
      checks++;
      if (obs[k] !== e) begin
        errors++;
        $display("FAIL %s_dut%0d got=%h exp=%h", tag, k, obs[k], e);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    model_reset();
    repeat (2) @(posedge pixclk);
    #1 en = 1'b1;
    #1 check_reset_vals("reset");
    @(negedge pixclk);
    en = 1'b0;
    rst = 1'b0;
    repeat (3) step(1'b0);
    step(1'b1);
    checks++;
    if (last_obs[0][5:3] !== 3'b011 || last_obs[0][27:17] !== 11'd0) begin
      errors++;
      $display("FAIL cold_first got=%h exp x=0 ls=1 fs=1 fetch=0", last_obs[0]);
    end
    step(1'b1);
    checks++;
    if (last_obs[0][27:17] !== 11'd1) begin
      errors++;
      $display("FAIL cold_second got x=%0d exp 1", last_obs[0][27:17]);
    end
  endtask

  task automatic test_line();
    while (!(mx[0] == 0 && my[0] == 1)) step(1'b1);
    n_hs0_low = 0; n_de0 = 0;
    repeat (800) step(1'b1);
    checks++;
    if (n_hs0_low != 96) begin errors++; $display("FAIL hsync_low_cycles got=%0d exp=96", n_hs0_low); end
    checks++;
    if (n_de0 != 640) begin errors++; $display("FAIL de_cycles got=%0d exp=640", n_de0); end
  endtask

  task automatic test_pipe();
    d2_fall_x = -1; d2_de_rise_x = -1; d2_de_rise_y = -1;
    repeat (800) step(1'b1);
    checks++;
    if (d2_fall_x != 658) begin errors++; $display("FAIL d2_hsync_fall got x=%0d exp=658", d2_fall_x); end
    checks++;
    if (d2_de_rise_x != 2 || d2_de_rise_y != 2) begin
      errors++;
      $display("FAIL d2_de_rise got x=%0d y=%0d exp x=2 y=2", d2_de_rise_x, d2_de_rise_y);
    end
  endtask

  task automatic test_small_frame();
    int guard = 0;
    while (!(mx[2] == 0 && my[2] == 0) && guard < 200) begin step(1'b1); guard++; end
    n_ls_s = 0; n_fs_s = 0; n_hs_s_hi = 0; n_vs_s_lo = 0;
    repeat (98) step(1'b1);
    step(1'b1);
    checks++;
    if (n_ls_s != 8 || n_fs_s != 2) begin
      errors++;
      $display("FAIL small_strobes got ls=%0d fs=%0d exp ls=8 fs=2", n_ls_s, n_fs_s);
    end
    checks++;
    if (fs_iv != 98) begin errors++; $display("FAIL small_frame_period got=%0d exp=98", fs_iv); end
    checks++;
    if (n_hs_s_hi != 21) begin errors++; $display("FAIL small_hsync_high got=%0d exp=21", n_hs_s_hi); end
    checks++;
    if (n_vs_s_lo != 14) begin errors++; $display("FAIL small_vsync_low got=%0d exp=14", n_vs_s_lo); end
  endtask

  task automatic test_pause();
    int guard = 0;
    int nfs;
    while (!(mx[0] == 300 && my[0] == 10) && guard < 10000) begin step(1'b1); guard++; end
    checks++;
    if (guard >= 10000) begin errors++; $display("FAIL pause_reach timeout got guard=%0d exp <10000", guard); end
    repeat (37) step(1'b0);
    checks++;
    if (last_obs[0][27:17] !== 11'd300 || last_obs[0][16:6] !== 11'd10 || last_obs[0][4:3] !== 2'b00) begin
      errors++;
      $display("FAIL pause_frozen got=%h exp x=300 y=10 strobes=0", last_obs[0]);
    end
    step(1'b1);
    step(1'b1);
    checks++;
    if (last_obs[0][27:17] !== 11'd301) begin
      errors++;
      $display("FAIL pause_resume got x=%0d exp 301", last_obs[0][27:17]);
    end
    nfs = n_fs_s;
    guard = 0;
    while (n_fs_s == nfs && guard < 200) begin step(1'b1); guard++; end
    checks++;
    if (fs_iv != 135) begin errors++; $display("FAIL pause_frame_period got=%0d exp=135", fs_iv); end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (mx[0] != 700 && guard < 1000) begin step(1'b1); guard++; end
    @(negedge pixclk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_reset_vals("async_rst");
    @(posedge pixclk);
    #2 rst = 1'b0;
    step(1'b1);
    checks++;
    if (last_obs[0][27:3] !== {22'd0, 3'b011}) begin
      errors++;
      $display("FAIL restart_first got=%h exp x=0 y=0 ls=1 fs=1", last_obs[0]);
    end
    repeat (900) step(1'b1);
  endtask

  initial begin
    ha  = '{640, 640, 8}; hfp = '{16, 16, 2}; hsw = '{96, 96, 3}; hbp = '{48, 48, 1};
    va  = '{480, 480, 4}; vfp = '{10, 10, 1}; vsw = '{2, 2, 1};   vbp = '{33, 33, 1};
    dl  = '{0, 2, 1};
    hp  = '{1'b0, 1'b0, 1'b1};
    vp  = '{1'b0, 1'b0, 1'b0};
    last_fs = 0; fs_iv = 0;
    d2_hs_prev = 1'b1; d2_de_prev = 1'b0;
    test_reset();
    test_line();
    test_pipe();
    test_small_frame();
    test_pause();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
